skolem_mirror_pipe: RTL

//   Parametrised, pipelined successor to the flat combinational Skolem mirror.

---
 rtl/skolem_pkg.sv | 45 ++++
 rtl/skolem_pipe_stage.sv | 33 +++
 rtl/skolem_mirror_pipe.sv | 117 +++++++++++
 3 files changed

// File: rtl/skolem_pkg.sv
// Shared types and helpers for the pipelined Skolem mirror.
//   mode_e        : function select carried with each accepted vector
//   skolem_apply  : y = f_mode(x) on an n-bit slice of a MAX_W-bit container
//   COUNT_W       : width of the completed-transfer counter
package skolem_pkg;

    localparam int unsigned COUNT_W = 32;
    // Widest vector the shared helper can handle; IDX_W indexes it.
    localparam int unsigned MAX_W   = 64;
    localparam int unsigned IDX_W   = 6;

    typedef enum logic [1:0] {
        MODE_IDENT = 2'b00,
        MODE_BREV  = 2'b01,
        MODE_INV   = 2'b10,
        MODE_ROTL  = 2'b11
    } mode_e;

    // Applies the selected mirror function to the low n bits of x; bits above n read as 0.
    function automatic logic [MAX_W-1:0] skolem_apply(
        input logic [MAX_W-1:0] x,
        input mode_e            mode,
        input int unsigned      n,
        input int unsigned      rot
    );
        logic [MAX_W-1:0] y;
        int unsigned      src;
        y = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            src = i;
            if (i < n) begin
                unique case (mode)
                    MODE_IDENT: src = i;
                    MODE_BREV:  src = n - 1 - i;
                    MODE_INV:   src = i;
                    MODE_ROTL:  src = (i + n - (rot % n)) % n;
                    default:    src = i;
                endcase
                y[i] = x[IDX_W'(src)] ^ (mode == MODE_INV);
            end
        end
        return y;
    endfunction

endpackage

// File: rtl/skolem_pipe_stage.sv
// One valid/ready register slice of the elastic pipeline.
//   clk, rst  : clock and synchronous active-high reset
//   load      : this slice may capture (it is empty or its contents move on)
//   up_valid  : upstream slot valid
//   up_data   : upstream payload, W bits
//   valid     : registered slot valid
//   data      : registered payload, W bits
module skolem_pipe_stage #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         up_valid,
    input  logic [W-1:0] up_data,
    output logic         valid,
    output logic [W-1:0] data
);

    // Payload only changes on a real capture so a stalled output stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/skolem_mirror_pipe.sv
// Pipelined Skolem mirror: y = f_mode(x) through a DEPTH-stage elastic pipe.
// Optional build macro: SKOLEM_CHECK_EN carries x/mode down the pipe and
// re-checks y at completion, raising sticky chk_err on any mismatch.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input handshake (in_ready is combinational)
//   in_x, in_mode       : N-bit vector and 2-bit function select
//   out_valid/out_ready : output handshake
//   out_y               : N-bit result, straight from the last stage register
//   out_count           : completed transfers, wraps at 2^32
//   chk_err             : sticky self-check error (0 when checking is off)
module skolem_mirror_pipe
    import skolem_pkg::*;
#(
    parameter int unsigned N     = 20,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned ROT   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_x,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out_y,
    output logic [COUNT_W-1:0] out_count,
    output logic               chk_err
);

`ifdef SKOLEM_CHECK_EN
    localparam int unsigned PW = 2 * N + 2;
`else
    localparam int unsigned PW = N;
`endif

    logic [N-1:0]  y_in;
    logic [PW-1:0] payload;
    logic [DEPTH:0] sv;
    logic [DEPTH:0] rdy;
    logic [PW-1:0] sd [DEPTH+1];
    logic [N-1:0]  y_last;

    // Mode is resolved at entry, so only y needs to travel down the pipe.
    always_comb begin
        y_in = N'(skolem_apply(MAX_W'(in_x), mode_e'(in_mode), N, ROT));
    end

`ifdef SKOLEM_CHECK_EN
    assign payload = {in_mode, in_x, y_in};
`else
    assign payload = y_in;
`endif

    // Ready ripples back from the consumer; an empty stage is always ready.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            rdy[k] = !sv[k+1] || rdy[k+1];
        end
    end

    assign sv[0]    = in_valid;
    assign sd[0]    = payload;
    assign in_ready = rdy[0];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        skolem_pipe_stage #(.W(PW)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .load     (rdy[k]),
            .up_valid (sv[k]),
            .up_data  (sd[k]),
            .valid    (sv[k+1]),
            .data     (sd[k+1])
        );
    end

    assign y_last    = sd[DEPTH][N-1:0];
    assign out_y     = y_last;
    assign out_valid = sv[DEPTH];

    // Completed-transfer counter; natural wrap at 2^COUNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_count <= '0;
        end else if (out_valid && out_ready) begin
            out_count <= out_count + COUNT_W'(1);
        end
    end

`ifdef SKOLEM_CHECK_EN
    logic [N-1:0] x_last;
    logic [1:0]   m_last;
    logic [N-1:0] y_ref_c;

    assign {m_last, x_last} = sd[DEPTH][PW-1:N];

    always_comb begin
        y_ref_c = N'(skolem_apply(MAX_W'(x_last), mode_e'(m_last), N, ROT));
    end

    // Sticky until reset: any completed vector whose y disagrees with its x/mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_err <= 1'b0;
        end else if (out_valid && out_ready && (y_ref_c != y_last)) begin
            chk_err <= 1'b1;
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule
